// File: rtl/wb_arbiter.sv
// Layer writeback arbiter: buffers one result per PE lane and funnels them
// round-robin into sequential FRAM writes starting at a latched base address.
module wb_arbiter #(
    parameter int PE_NUM    = 8,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        output_baseaddr,
    input  logic                     flush,
    input  logic [PE_NUM-1:0]        pe_out_en,
    input  logic [PE_NUM*DATA_W-1:0] pe_out_data,
    output logic                     fram_wr_en,
    output logic [ADDR_W-1:0]        fram_wr_addr,
    output logic [DATA_W-1:0]        fram_wr_data,
    input  logic                     fram_wr_ready,
    output logic                     wb_busy,
    output logic                     wb_done,
    output logic                     overflow
);

    localparam int                PTR_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg, idx_reg;
    logic [PE_NUM-1:0]   pending_reg, pending_next, buf_load, lane_drop;
    logic [DATA_W-1:0]   buf_reg [PE_NUM];
    logic [PTR_W-1:0]    rr_ptr_reg, grant_lane;
    logic                grant_valid, out_free, lane_active, drain_done;
    logic                fram_wr_en_reg, wb_done_reg, overflow_reg;
    logic [ADDR_W-1:0]   fram_wr_addr_reg;
    logic [DATA_W-1:0]   fram_wr_data_reg;

    assign lane_active = (state_reg != IDLE);
    assign out_free    = !fram_wr_en_reg || fram_wr_ready;
    assign drain_done  = (state_reg == DRAIN) && (pending_reg == '0) && out_free;

    // Round-robin search starting one past the most recently granted lane.
    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_lane  = '0;
        cand        = 0;
        for (int k = 0; k < PE_NUM; k++) begin
            cand = (int'(rr_ptr_reg) + k) % PE_NUM;
            if (!grant_valid && lane_active && out_free && pending_reg[PTR_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_lane  = PTR_W'(cand);
            end
        end
    end

    // A granted lane frees its buffer this cycle, so a same-cycle strobe refills it.
    generate
        for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_lane
            logic lane_granted, capture;
            assign lane_granted     = grant_valid && (grant_lane == PTR_W'(gi));
            assign capture          = lane_active && pe_out_en[gi];
            assign buf_load[gi]     = capture && (!pending_reg[gi] || lane_granted);
            assign lane_drop[gi]    = capture && pending_reg[gi] && !lane_granted;
            assign pending_next[gi] = buf_load[gi] || (pending_reg[gi] && !lane_granted);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = ACTIVE;
            ACTIVE:  if (flush)      state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PE_NUM; i++) buf_reg[i] <= '0;
        end else begin
            for (int i = 0; i < PE_NUM; i++)
                if (buf_load[i]) buf_reg[i] <= pe_out_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            base_reg         <= '0;
            idx_reg          <= '0;
            pending_reg      <= '0;
            rr_ptr_reg       <= '0;
            fram_wr_en_reg   <= 1'b0;
            fram_wr_addr_reg <= '0;
            fram_wr_data_reg <= '0;
            wb_done_reg      <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            wb_done_reg <= drain_done;
            if (state_reg == IDLE && start) begin
                base_reg     <= output_baseaddr;
                idx_reg      <= '0;
                overflow_reg <= 1'b0;
            end else if (|lane_drop) begin
                overflow_reg <= 1'b1;
            end
            if (grant_valid) begin
                fram_wr_en_reg   <= 1'b1;
                fram_wr_addr_reg <= base_reg + idx_reg * STEP;
                fram_wr_data_reg <= buf_reg[grant_lane];
                idx_reg          <= idx_reg + 1'b1;
                rr_ptr_reg       <= (grant_lane == PTR_W'(PE_NUM - 1)) ? '0 : grant_lane + 1'b1;
            end else if (fram_wr_ready) begin
                fram_wr_en_reg <= 1'b0;
            end
        end
    end

    assign fram_wr_en   = fram_wr_en_reg;
    assign fram_wr_addr = fram_wr_addr_reg;
    assign fram_wr_data = fram_wr_data_reg;
    assign wb_done      = wb_done_reg;
    assign overflow     = overflow_reg;
    assign wb_busy      = lane_active && ((|pending_reg) || fram_wr_en_reg);

endmodule
